mnist_argmax_seq: RTL and testbench
===================================

# mnist_argmax_seq

Post-processing stage downstream of the fixed-point ReLU inference top level. After the engine asserts `done`, it walks the engine's `out_idx` score-select port over classes 0..9 and tracks the highest and second-highest signed scores. It then presents the predicted digit, its score and a confidence margin on a valid/ready handshake. It is the last stage before the result is consumed (UART reporter, testbench scoreboard or LED driver).

## Interface
- `DATA_WIDTH`, 15, width of a signed class score.
- `NUM_CLASSES`, 10, number of classes scanned; must be ≤ 16.
- `IDX_WIDTH`, 4, width of the class index.
- `clk  in  1`  single clock; all logic on rising edge.
- `rst  in  1`  reset; synchronous and active-low (state clears on a rising `clk` edge with `rst`=0).
- `engine_done  in  1`  `done` from the inference top; a level that stays high until the engine is restarted.
- `out_idx  out  IDX_WIDTH`  class select to the inference top.
- `score  in  signed DATA_WIDTH`  selected score; combinationally valid in the same cycle `out_idx` is driven.
- `busy  out  1`  high in SCAN and HOLD.
- `result_valid  out  1`  result available.
- `result_ready  in  1`  consumer accepts the result.
- `result_digit  out  IDX_WIDTH`  argmax class.
- `result_score  out  signed DATA_WIDTH`  score of the argmax class.
- `result_margin  out  unsigned DATA_WIDTH+1`  best minus second-best score.
- `overrun  out  1`  sticky; a `engine_done` rising edge was seen while `busy`.

## Operation
- Rising-edge detect on `engine_done` using a registered copy (`done_q`, reset to 1, so a `done` held high through reset does not trigger). Edge = `engine_done & ~done_q`.
- States:
  - IDLE: `out_idx`=0. On an edge, go to SCAN with `idx`=0.
  - SCAN: `out_idx`=`idx`; sample `score` each cycle.
    - At `idx`=0: `best`=`score`, `best_idx`=0, `second`=most-negative value (−2^(DATA_WIDTH−1)).
    - At later `idx`: if `score` > `best`, then `second`←`best`, `best`←`score`, `best_idx`←`idx`. Else if `score` > `second`, then `second`←`score`.
    - At `idx`=NUM_CLASSES−1, go to HOLD. Otherwise `idx`+1.
  - HOLD: `result_valid`=1; all result outputs stable. When `result_valid & result_ready`, return to IDLE.
- Comparisons are signed and strict. On a tie for best, the lowest index wins; the tied score becomes `second` and the margin is 0.
- `result_margin` = `best` − `second`, computed in DATA_WIDTH+1 bits with sign extension. It is always ≥ 0. Maximum is 2^DATA_WIDTH − 1 (best 16383, second −16384).
- Result registers update only when SCAN→HOLD; they hold their last values in IDLE.
- An edge while `busy` is ignored and sets `overrun`. `overrun` clears only on reset.
- Reset mid-SCAN or mid-HOLD aborts the scan, returns to IDLE and drops `result_valid` on the next edge; no partial result is retained.

## Timing
- Reset values: `out_idx`=0, `busy`=0, `result_valid`=0, `result_digit`=0, `result_score`=0, `result_margin`=0, `overrun`=0.
- An edge sampled at cycle N → SCAN occupies cycles N+1..N+NUM_CLASSES with `out_idx` = 0..9.
- `result_valid` rises at cycle N+NUM_CLASSES+1 (N+11 by default).
- `result_ready` may be high before `result_valid`. Transfer is on the first cycle both are high. `result_valid` is low the following cycle.
- Throughput: the earliest new edge is accepted in the cycle after transfer (IDLE).
- `busy` is high from N+1 through the transfer cycle inclusive.

## Test plan
- Scores {0:−5, 1:3, 2:100, 3:7, 4:99, 5:−100, 6:0, 7:1, 8:2, 9:50}, `result_ready`=1 → at N+11: digit 2, score 100, margin 1; `out_idx` sequence 0..9 at N+1..N+10.
- All scores equal to −16384 → digit 0, score −16384, margin 0. Scores with 42 at indices 3 and 7 (others −1) → digit 3, margin 0.
- Extremes: index 9 = 16383, all others −16384 → digit 9, margin 32767 (no overflow).
- Backpressure: `result_ready` held low 20 cycles → `result_valid` and outputs stable. A second `done` edge during the hold → ignored and `overrun`=1. Raising ready → transfer, then IDLE.
- `engine_done` held high across reset release → no scan starts. A later low→high transition → scan starts.
- Reset asserted at SCAN `idx`=5 → next cycle: IDLE, `out_idx`=0, `busy`=0, `result_valid`=0. A new edge produces the correct full result.

Source files
------------

// File: rtl/mnist_argmax_seq_if.sv
// mnist_argmax_seq_if
// Result handshake between the argmax stage and whatever consumes the
// prediction (UART reporter, LED driver, scoreboard).
//   result_valid   producer -> consumer  a prediction is being presented
//   result_ready   consumer -> producer  the consumer takes it this cycle
//   result_digit   producer -> consumer  argmax class index
//   result_score   producer -> consumer  signed score of that class
//   result_margin  producer -> consumer  best minus second-best score (>= 0)
interface mnist_argmax_seq_if #(
  parameter int DATA_WIDTH = 15,
  parameter int IDX_WIDTH  = 4
);
  logic                         result_valid;
  logic                         result_ready;
  logic [IDX_WIDTH-1:0]         result_digit;
  logic signed [DATA_WIDTH-1:0] result_score;
  logic [DATA_WIDTH:0]          result_margin;

  modport master (
    output result_valid,
    input  result_ready,
    output result_digit,
    output result_score,
    output result_margin
  );

  modport slave (
    input  result_valid,
    output result_ready,
    input  result_digit,
    input  result_score,
    input  result_margin
  );
endinterface

// File: rtl/mnist_argmax_seq.sv
// mnist_argmax_seq
// After the inference engine raises done, walks its score-select port over
// every class, keeps the highest and second-highest signed scores, and
// presents digit / score / margin on a valid-ready handshake.
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-low reset
//   engine_done  level done flag from the inference top (rising edge starts)
//   out_idx      class select driven back to the inference top
//   score        selected class score, valid combinationally with out_idx
//   busy         high while scanning or holding a result
//   overrun      sticky: a done edge arrived while busy
//   res          result handshake (master side)
module mnist_argmax_seq #(
  parameter int DATA_WIDTH  = 15,
  parameter int NUM_CLASSES = 10,
  parameter int IDX_WIDTH   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         engine_done,
  output logic [IDX_WIDTH-1:0]         out_idx,
  input  logic signed [DATA_WIDTH-1:0] score,
  output logic                         busy,
  output logic                         overrun,
  mnist_argmax_seq_if.master           res
);

  typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

  localparam logic signed [DATA_WIDTH-1:0] SCORE_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [IDX_WIDTH-1:0]         LAST_IDX  = IDX_WIDTH'(NUM_CLASSES - 1);

  // Difference is formed one bit wider so best=max, second=min cannot wrap.
  function automatic logic [DATA_WIDTH:0] margin_f(
    input logic signed [DATA_WIDTH-1:0] hi,
    input logic signed [DATA_WIDTH-1:0] lo
  );
    logic signed [DATA_WIDTH:0] diff;
    diff = {hi[DATA_WIDTH-1], hi} - {lo[DATA_WIDTH-1], lo};
    return diff;
  endfunction

  state_t                       state, state_nxt;
  logic                         done_q;
  logic                         start_edge;
  logic [IDX_WIDTH-1:0]         idx;
  logic                         last;
  logic                         transfer;

  logic signed [DATA_WIDTH-1:0] best, second;
  logic [IDX_WIDTH-1:0]         best_idx;
  logic signed [DATA_WIDTH-1:0] best_nxt, second_nxt;
  logic [IDX_WIDTH-1:0]         best_idx_nxt;

  assign start_edge = engine_done & ~done_q;
  assign last       = (idx == LAST_IDX);
  assign transfer   = res.result_valid & res.result_ready;

  always_comb begin
    state_nxt        = state;
    out_idx          = '0;
    busy             = 1'b0;
    res.result_valid = 1'b0;
    case (state)
      IDLE: begin
        if (start_edge) state_nxt = SCAN;
      end
      SCAN: begin
        out_idx = idx;
        busy    = 1'b1;
        if (last) state_nxt = HOLD;
      end
      HOLD: begin
        busy             = 1'b1;
        res.result_valid = 1'b1;
        if (res.result_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Strict compares: an equal score never displaces best, so the lowest
  // index wins a tie and the tied value lands in second (margin 0).
  always_comb begin
    best_nxt     = best;
    second_nxt   = second;
    best_idx_nxt = best_idx;
    if (idx == '0) begin
      best_nxt     = score;
      second_nxt   = SCORE_MIN;
      best_idx_nxt = '0;
    end else if (score > best) begin
      second_nxt   = best;
      best_nxt     = score;
      best_idx_nxt = idx;
    end else if (score > second) begin
      second_nxt   = score;
    end
  end

  // ---- state / control registers ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      done_q  <= 1'b1;
      idx     <= '0;
      overrun <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= engine_done;
      if (state == SCAN) idx <= idx + IDX_WIDTH'(1);
      else               idx <= '0;
      if (start_edge && busy) overrun <= 1'b1;
    end
  end

  // ---- running best / second tracking ----
  always_ff @(posedge clk) begin
    if (state == SCAN) begin
      best     <= best_nxt;
      second   <= second_nxt;
      best_idx <= best_idx_nxt;
    end
  end

  // ---- result registers, loaded on the final scan cycle ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      res.result_digit  <= '0;
      res.result_score  <= '0;
      res.result_margin <= '0;
    end else if (state == SCAN && last) begin
      res.result_digit  <= best_idx_nxt;
      res.result_score  <= best_nxt;
      res.result_margin <= margin_f(best_nxt, second_nxt);
    end
  end

  logic unused_transfer;
  assign unused_transfer = transfer;

endmodule

// File: tb/tb_mnist_argmax_seq.sv
// tb_mnist_argmax_seq
// Directed bench: a score table stands in for the inference engine and is
// indexed by out_idx; expected results are hand-computed constants.
module tb_mnist_argmax_seq;

  logic                clk;
  logic                rst;
  logic                engine_done;
  logic [3:0]          out_idx;
  logic signed [14:0]  score;
  logic                busy;
  logic                overrun;
  logic signed [14:0]  scores [16];

  int checks;
  int errors;

  mnist_argmax_seq_if #(.DATA_WIDTH(15), .IDX_WIDTH(4)) res ();

  mnist_argmax_seq #(
    .DATA_WIDTH (15),
    .NUM_CLASSES(10),
    .IDX_WIDTH  (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .engine_done(engine_done),
    .out_idx    (out_idx),
    .score      (score),
    .busy       (busy),
    .overrun    (overrun),
    .res        (res)
  );

  always_comb score = scores[out_idx];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int v0, v1, v2, v3, v4, v5, v6, v7, v8, v9);
    scores[0] = 15'(v0); scores[1] = 15'(v1); scores[2] = 15'(v2);
    scores[3] = 15'(v3); scores[4] = 15'(v4); scores[5] = 15'(v5);
    scores[6] = 15'(v6); scores[7] = 15'(v7); scores[8] = 15'(v8);
    scores[9] = 15'(v9);
  endtask

  // Full scan with ready already high: checks the index walk, the result
  // cycle, and the return to idle.
  task automatic run_scan(input string tag, input int digit, input int sc, input int margin);
    res.result_ready = 1'b1;
    engine_done = 1'b1;
    step();                        // edge sampled at this edge (cycle N)
    for (int k = 0; k < 10; k++) begin
      chk({tag, "_idx"}, int'(out_idx), k);
      chk({tag, "_busy"}, int'(busy), 1);
      chk({tag, "_vld_lo"}, int'(res.result_valid), 0);
      step();
    end
    chk({tag, "_vld"}, int'(res.result_valid), 1);
    chk({tag, "_digit"}, int'(res.result_digit), digit);
    chk({tag, "_score"}, int'(res.result_score), sc);
    chk({tag, "_margin"}, int'(res.result_margin), margin);
    engine_done = 1'b0;
    step();
    chk({tag, "_vld_after"}, int'(res.result_valid), 0);
    chk({tag, "_busy_after"}, int'(busy), 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 16; i++) scores[i] = '0;
    rst = 1'b0;
    engine_done = 1'b0;
    res.result_ready = 1'b0;
    repeat (3) step();

    chk("rst_out_idx", int'(out_idx), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(res.result_valid), 0);
    chk("rst_digit", int'(res.result_digit), 0);
    chk("rst_score", int'(res.result_score), 0);
    chk("rst_margin", int'(res.result_margin), 0);
    chk("rst_overrun", int'(overrun), 0);
    rst = 1'b1;
    step();

    load(-5, 3, 100, 7, 99, -100, 0, 1, 2, 50);
    run_scan("mixed", 2, 100, 1);

    load(-16384, -16384, -16384, -16384, -16384, -16384, -16384, -16384, -16384, -16384);
    run_scan("allmin", 0, -16384, 0);

    load(-1, -1, -1, 42, -1, -1, -1, 42, -1, -1);
    run_scan("tie", 3, 42, 0);

    load(-16384, -16384, -16384, -16384, -16384, -16384, -16384, -16384, -16384, 16383);
    run_scan("extreme", 9, 16383, 32767);

    // Backpressure with a second done edge during the hold.
    load(-5, 3, 100, 7, 99, -100, 0, 1, 2, 50);
    res.result_ready = 1'b0;
    engine_done = 1'b1;
    repeat (11) step();
    chk("bp_vld", int'(res.result_valid), 1);
    engine_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("bp_hold_vld", int'(res.result_valid), 1);
      chk("bp_hold_digit", int'(res.result_digit), 2);
      chk("bp_hold_score", int'(res.result_score), 100);
      chk("bp_hold_margin", int'(res.result_margin), 1);
      if (i == 5) engine_done = 1'b1;
    end
    chk("bp_overrun", int'(overrun), 1);
    chk("bp_busy", int'(busy), 1);
    res.result_ready = 1'b1;
    step();
    chk("bp_vld_after", int'(res.result_valid), 0);
    chk("bp_busy_after", int'(busy), 0);
    chk("bp_overrun_sticky", int'(overrun), 1);
    engine_done = 1'b0;
    step();

    // done held high through reset release must not start a scan.
    rst = 1'b0;
    engine_done = 1'b1;
    repeat (2) step();
    rst = 1'b1;
    repeat (5) begin
      step();
      chk("dhold_busy", int'(busy), 0);
      chk("dhold_out_idx", int'(out_idx), 0);
    end
    chk("dhold_overrun", int'(overrun), 0);
    chk("dhold_digit", int'(res.result_digit), 0);
    engine_done = 1'b0;
    step();
    load(-5, 3, 100, 7, 99, -100, 0, 1, 2, 50);
    run_scan("after_dhold", 2, 100, 1);

    // Reset in the middle of a scan.
    engine_done = 1'b1;
    repeat (6) step();
    chk("mid_idx5", int'(out_idx), 5);
    rst = 1'b0;
    step();
    chk("mid_out_idx", int'(out_idx), 0);
    chk("mid_busy", int'(busy), 0);
    chk("mid_valid", int'(res.result_valid), 0);
    rst = 1'b1;
    engine_done = 1'b0;
    step();
    load(-16384, -16384, -16384, -16384, -16384, -16384, -16384, -16384, -16384, 16383);
    run_scan("after_mid", 9, 16383, 32767);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
